// File: rtl/memory_access.sv
// Y86 SEQ memory stage: performs the one data-memory access an instruction needs over a
// req/ack bus, returns valM and the instruction status, and holds busy while occupied.
module memory_access #(
  parameter int DATA_W    = 64,
  parameter int MEM_BYTES = 4096,
  parameter int TIMEOUT   = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [3:0]        icode_i,
  input  logic [DATA_W-1:0] valE_i,
  input  logic [DATA_W-1:0] valA_i,
  input  logic [DATA_W-1:0] valP_i,
  output logic              dmem_req_o,
  output logic              dmem_we_o,
  output logic [DATA_W-1:0] dmem_addr_o,
  output logic [DATA_W-1:0] dmem_wdata_o,
  input  logic              dmem_ack_i,
  input  logic [DATA_W-1:0] dmem_rdata_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [DATA_W-1:0] valM_o,
  output logic [2:0]        stat_o
);

  localparam logic [3:0] I_HALT   = 4'h0;
  localparam logic [3:0] I_RMMOVQ = 4'h4;
  localparam logic [3:0] I_MRMOVQ = 4'h5;
  localparam logic [3:0] I_CALL   = 4'h8;
  localparam logic [3:0] I_RET    = 4'h9;
  localparam logic [3:0] I_PUSHQ  = 4'hA;
  localparam logic [3:0] I_POPQ   = 4'hB;

  localparam logic [2:0] S_AOK = 3'd1;
  localparam logic [2:0] S_HLT = 3'd2;
  localparam logic [2:0] S_ADR = 3'd3;
  localparam logic [2:0] S_INS = 3'd4;

  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
  // One extra bit so an address close to 2^DATA_W cannot wrap into the legal window.
  localparam logic [DATA_W:0] ADDR_MAX = (DATA_W + 1)'(MEM_BYTES - 8);

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    DONE
  } state_t;

  state_t            state_reg, state_next;
  logic              read_reg, read_next;
  logic              we_reg, we_next;
  logic [DATA_W-1:0] addr_reg, addr_next;
  logic [DATA_W-1:0] wdata_reg, wdata_next;
  logic [CNT_W-1:0]  cnt_reg, cnt_next;
  logic [DATA_W-1:0] valm_reg, valm_next;
  logic [2:0]        stat_reg, stat_next;

  logic              dec_read;
  logic              dec_write;
  logic [DATA_W-1:0] dec_addr;
  logic [DATA_W-1:0] dec_wdata;
  logic              dec_illegal;

  assign dec_read    = (icode_i == I_MRMOVQ) || (icode_i == I_POPQ) || (icode_i == I_RET);
  assign dec_write   = (icode_i == I_RMMOVQ) || (icode_i == I_PUSHQ) || (icode_i == I_CALL);
  assign dec_addr    = ((icode_i == I_POPQ) || (icode_i == I_RET)) ? valA_i : valE_i;
  assign dec_wdata   = (icode_i == I_CALL) ? valP_i : valA_i;
  assign dec_illegal = {1'b0, dec_addr} > ADDR_MAX;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= IDLE;
      read_reg  <= 1'b0;
      we_reg    <= 1'b0;
      addr_reg  <= '0;
      wdata_reg <= '0;
      cnt_reg   <= '0;
      valm_reg  <= '0;
      stat_reg  <= S_AOK;
    end else begin
      state_reg <= state_next;
      read_reg  <= read_next;
      we_reg    <= we_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
      cnt_reg   <= cnt_next;
      valm_reg  <= valm_next;
      stat_reg  <= stat_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    read_next  = read_reg;
    we_next    = we_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    cnt_next   = cnt_reg;
    valm_next  = valm_reg;
    stat_next  = stat_reg;

    case (state_reg)
      IDLE: begin
        if (valid_i) begin
          if (icode_i > I_POPQ) begin
            state_next = DONE;
            stat_next  = S_INS;
            valm_next  = '0;
          end else if (icode_i == I_HALT) begin
            state_next = DONE;
            stat_next  = S_HLT;
            valm_next  = '0;
          end else if (dec_read || dec_write) begin
            if (dec_illegal) begin
              state_next = DONE;
              stat_next  = S_ADR;
              valm_next  = '0;
            end else begin
              // Bus fields are only latched for a real access so they stay put otherwise.
              state_next = REQ;
              read_next  = dec_read;
              we_next    = dec_write;
              addr_next  = dec_addr;
              wdata_next = dec_wdata;
              cnt_next   = '0;
            end
          end else begin
            state_next = DONE;
            stat_next  = S_AOK;
            valm_next  = '0;
          end
        end
      end
      REQ: begin
        if (dmem_ack_i) begin
          state_next = DONE;
          stat_next  = S_AOK;
          valm_next  = read_reg ? dmem_rdata_i : '0;
        end else if (cnt_reg == CNT_LAST) begin
          state_next = DONE;
          stat_next  = S_ADR;
          valm_next  = '0;
        end else begin
          cnt_next = cnt_reg + CNT_W'(1);
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  assign dmem_req_o   = (state_reg == REQ);
  assign dmem_we_o    = we_reg;
  assign dmem_addr_o  = addr_reg;
  assign dmem_wdata_o = wdata_reg;
  assign busy_o       = (state_reg != IDLE);
  assign done_o       = (state_reg == DONE);
  assign valM_o       = valm_reg;
  assign stat_o       = stat_reg;

endmodule

// File: tb/tb_memory_access.sv
// Directed bench for memory_access: inputs driven and outputs sampled on the falling edge,
// with the ack bus played by hand from each test sequence.
module tb_memory_access;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [3:0]  icode_i;
  logic [63:0] valE_i, valA_i, valP_i;
  logic        dmem_req_o, dmem_we_o;
  logic [63:0] dmem_addr_o, dmem_wdata_o;
  logic        dmem_ack_i;
  logic [63:0] dmem_rdata_i;
  logic        busy_o, done_o;
  logic [63:0] valM_o;
  logic [2:0]  stat_o;

  int n_checks = 0;
  int n_pass   = 0;

  always #5 clk_i = ~clk_i;

  memory_access #(.DATA_W(64), .MEM_BYTES(4096), .TIMEOUT(16)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i), .icode_i(icode_i),
    .valE_i(valE_i), .valA_i(valA_i), .valP_i(valP_i),
    .dmem_req_o(dmem_req_o), .dmem_we_o(dmem_we_o), .dmem_addr_o(dmem_addr_o),
    .dmem_wdata_o(dmem_wdata_o), .dmem_ack_i(dmem_ack_i), .dmem_rdata_i(dmem_rdata_i),
    .busy_o(busy_o), .done_o(done_o), .valM_o(valM_o), .stat_o(stat_o)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) begin
      n_pass++;
      $display("ok   %s: 0x%0h", tag, got);
    end else begin
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk_i);
  endtask

  // Presents one instruction in cycle N; returns at the falling edge of cycle N+1.
  task automatic issue(input logic [3:0] ic, input logic [63:0] e, input logic [63:0] a,
                       input logic [63:0] p);
    valid_i = 1'b1;
    icode_i = ic;
    valE_i  = e;
    valA_i  = a;
    valP_i  = p;
    tick();
    valid_i = 1'b0;
  endtask

  initial begin
    int reqc;
    bit seen_done;
    rst_i = 1'b1; valid_i = 1'b0; icode_i = '0; valE_i = '0; valA_i = '0; valP_i = '0;
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    tick(); tick();
    check("rst_req", {63'd0, dmem_req_o}, 64'd0);
    check("rst_busy", {63'd0, busy_o}, 64'd0);
    check("rst_done", {63'd0, done_o}, 64'd0);
    check("rst_stat", {61'd0, stat_o}, 64'd1);
    check("rst_valm", valM_o, 64'd0);
    check("rst_addr", dmem_addr_o, 64'd0);
    rst_i = 1'b0;
    tick();

    // MRMOVQ read, ack in N+3
    issue(4'h5, 64'h100, 64'h0, 64'h0);
    check("t1_req", {63'd0, dmem_req_o}, 64'd1);
    check("t1_we", {63'd0, dmem_we_o}, 64'd0);
    check("t1_addr", dmem_addr_o, 64'h100);
    check("t1_busy", {63'd0, busy_o}, 64'd1);
    tick();
    check("t1_req_held", {63'd0, dmem_req_o}, 64'd1);
    tick();
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'hDEADBEEF;
    tick();
    dmem_ack_i = 1'b0; dmem_rdata_i = '0;
    check("t1_done", {63'd0, done_o}, 64'd1);
    check("t1_busy_in_done", {63'd0, busy_o}, 64'd1);
    check("t1_valm", valM_o, 64'hDEADBEEF);
    check("t1_stat", {61'd0, stat_o}, 64'd1);
    tick();
    check("t1_done_pulse", {63'd0, done_o}, 64'd0);
    check("t1_idle", {63'd0, busy_o}, 64'd0);
    check("t1_valm_hold", valM_o, 64'hDEADBEEF);

    // OPQ needs no access: valM clears
    issue(4'h6, 64'h7, 64'h8, 64'h9);
    check("t5_opq_req", {63'd0, dmem_req_o}, 64'd0);
    check("t5_opq_done", {63'd0, done_o}, 64'd1);
    check("t5_opq_stat", {61'd0, stat_o}, 64'd1);
    check("t5_opq_valm", valM_o, 64'd0);
    tick();

    // CALL write at the last legal address, ack in N+1
    issue(4'h8, 64'hFF8, 64'h11, 64'h42);
    check("t2_req", {63'd0, dmem_req_o}, 64'd1);
    check("t2_we", {63'd0, dmem_we_o}, 64'd1);
    check("t2_addr", dmem_addr_o, 64'hFF8);
    check("t2_wdata", dmem_wdata_o, 64'h42);
    dmem_ack_i = 1'b1;
    tick();
    dmem_ack_i = 1'b0;
    check("t2_done", {63'd0, done_o}, 64'd1);
    check("t2_stat", {61'd0, stat_o}, 64'd1);
    check("t2_req_off", {63'd0, dmem_req_o}, 64'd0);
    tick();

    // POPQ addresses via valA; 0xFFC is out of range
    issue(4'hB, 64'h10, 64'hFFC, 64'h0);
    check("t3_req", {63'd0, dmem_req_o}, 64'd0);
    check("t3_done", {63'd0, done_o}, 64'd1);
    check("t3_stat", {61'd0, stat_o}, 64'd3);
    tick();

    // Address near 2^64 must not wrap into the legal range
    issue(4'h4, 64'hFFFF_FFFF_FFFF_FFFC, 64'h1, 64'h0);
    check("wrap_req", {63'd0, dmem_req_o}, 64'd0);
    check("wrap_stat", {61'd0, stat_o}, 64'd3);
    tick();

    // RMMOVQ with no ack: timeout after exactly 16 request cycles
    issue(4'h4, 64'h200, 64'h55, 64'h0);
    check("t4_wdata", dmem_wdata_o, 64'h55);
    reqc = dmem_req_o ? 1 : 0;
    seen_done = 1'b0;
    for (int i = 0; i < 40; i++) begin
      tick();
      if (done_o) begin
        seen_done = 1'b1;
        break;
      end
      if (dmem_req_o) reqc++;
    end
    check("t4_done_seen", {63'd0, seen_done}, 64'd1);
    check("t4_req_cycles", 64'(reqc), 64'd16);
    check("t4_stat", {61'd0, stat_o}, 64'd3);
    check("t4_req_off", {63'd0, dmem_req_o}, 64'd0);
    tick();

    // Invalid instruction, then halt
    issue(4'hC, 64'h0, 64'h0, 64'h0);
    check("t5_ins_done", {63'd0, done_o}, 64'd1);
    check("t5_ins_stat", {61'd0, stat_o}, 64'd4);
    tick();
    issue(4'h0, 64'h0, 64'h0, 64'h0);
    check("t5_hlt_done", {63'd0, done_o}, 64'd1);
    check("t5_hlt_stat", {61'd0, stat_o}, 64'd2);
    tick();

    // Valid while busy is ignored; reset mid-REQ drops req and ignores a late ack
    issue(4'h5, 64'h300, 64'h0, 64'h0);
    check("t6_req", {63'd0, dmem_req_o}, 64'd1);
    valid_i = 1'b1; icode_i = 4'hC;
    tick();
    valid_i = 1'b0;
    check("t6_ignored_req", {63'd0, dmem_req_o}, 64'd1);
    check("t6_ignored_done", {63'd0, done_o}, 64'd0);
    rst_i = 1'b1;
    tick();
    rst_i = 1'b0;
    check("t6_rst_req", {63'd0, dmem_req_o}, 64'd0);
    check("t6_rst_busy", {63'd0, busy_o}, 64'd0);
    check("t6_rst_stat", {61'd0, stat_o}, 64'd1);
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h1234;
    tick();
    dmem_ack_i = 1'b0;
    check("t6_late_done", {63'd0, done_o}, 64'd0);
    check("t6_late_busy", {63'd0, busy_o}, 64'd0);
    check("t6_late_valm", valM_o, 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
